// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounced three-key BCD stopwatch / countdown timer.
//   clk      system clock
//   rst      synchronous active-high reset
//   KEY[2:0] raw active-low keys: [0]=start/pause, [1]=clear, [2]=direction
//   HEX      NUM_DIGITS active-low seven-segment digits, digit i at [7i+6:7i] (gfedcba)
//   LED_RED  status bar: [0]=RUN [1]=DOWN [2]=PAUSE [3]=tick, all ones in DONE
// Optional: define LEADING_ZERO_BLANK_EN to blank leading-zero digits above digit 0.
module stopwatch_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV = 50000000,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter logic [4*NUM_DIGITS-1:0] PRESET = 'h0030,
  parameter int LED_W = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              KEY,
  output logic [7*NUM_DIGITS-1:0] HEX,
  output logic [LED_W-1:0]        LED_RED
);
  localparam int CW = 4 * NUM_DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [2:0]         sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]         vld_q, vld_d;
  logic [2:0]         acc_q, acc_d, arm_q, arm_d, press;
  logic [2:0][DW-1:0] dbc_q, dbc_d;
  logic [1:0]         state_q, state_d;
  logic               dir_q, dir_d, tick;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]      pre_q, pre_d;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic               k0, k1, k2;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h40; 4'd1: seg7 = 7'h79; 4'd2: seg7 = 7'h24; 4'd3: seg7 = 7'h30;
      4'd4: seg7 = 7'h19; 4'd5: seg7 = 7'h12; 4'd6: seg7 = 7'h02; 4'd7: seg7 = 7'h78;
      4'd8: seg7 = 7'h00; 4'd9: seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // One BCD increment/decrement with decimal carry/borrow rippling upward.
  function automatic logic [CW-1:0] bcd_step(input logic [CW-1:0] v, input logic down);
    logic c;
    logic [3:0] d;
    bcd_step = v;
    c = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = v[4*i +: 4];
      if (c) begin
        if (down) begin
          if (d == 4'd0) d = 4'd9;
          else begin d = d - 4'd1; c = 1'b0; end
        end else begin
          if (d == 4'd9) d = 4'd0;
          else begin d = d + 4'd1; c = 1'b0; end
        end
      end
      bcd_step[4*i +: 4] = d;
    end
  endfunction

  // Key path. vld marks when sync2 holds post-reset samples. A key is only
  // armed after a stable released level has been seen, so a key held through
  // reset yields no event until it is released and pressed again.
  always_comb begin
    sync1_d = KEY;
    sync2_d = sync1_q;
    vld_d   = {vld_q[0], 1'b1};
    acc_d   = acc_q;
    arm_d   = arm_q;
    press   = '0;
    dbc_d   = '0;
    for (int k = 0; k < 3; k++) begin
      // Unarmed keys compare against "pressed" to detect the first release.
      if (vld_q[1] && (sync2_q[k] != (arm_q[k] & acc_q[k]))) begin
        if (dbc_q[k] == DW'(DEBOUNCE_CYCLES - 1)) begin
          if (arm_q[k]) begin
            acc_d[k] = sync2_q[k];
            press[k] = ~sync2_q[k];
          end else begin
            arm_d[k] = 1'b1;
          end
        end else begin
          dbc_d[k] = dbc_q[k] + DW'(1);
        end
      end
    end
  end

  assign k1 = press[1];
  assign k0 = press[0] & ~press[1];
  assign k2 = press[2] & ~press[1] & ~press[0];
  assign tick = (state_q == S_RUN) && (pre_q == PW'(TICK_DIV - 1));

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    case (state_q)
      S_IDLE: begin
        pre_d = '0;
        if (k0) state_d = S_RUN;
        else if (k2) begin
          dir_d = ~dir_q;
          cnt_d = ~dir_q ? PRESET : '0;
        end
      end
      S_RUN: begin
        pre_d = tick ? '0 : pre_q + PW'(1);
        if (dir_q && cnt_q == '0) begin
          state_d = S_DONE;
          pre_d   = '0;
        end else begin
          if (tick) begin
            cnt_d = bcd_step(cnt_q, dir_q);
            if (dir_q && cnt_d == '0) begin
              state_d = S_DONE;
              pre_d   = '0;
            end
          end
          // Reaching zero takes precedence over a coincident pause.
          if (state_d == S_RUN && k0) state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (k1) begin
          state_d = S_IDLE;
          pre_d   = '0;
          cnt_d   = dir_q ? PRESET : '0;
        end else if (k0) state_d = S_RUN;
        else if (k2) begin
          dir_d = ~dir_q;
          cnt_d = ~dir_q ? PRESET : '0;
        end
      end
      default: begin
        pre_d = '0;
        if (k0 || k1) begin
          state_d = S_IDLE;
          cnt_d   = dir_q ? PRESET : '0;
        end
      end
    endcase
  end

  always_comb begin
    logic lead;
    logic [3:0] d;
    hex_d = '0;
    lead  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      d = cnt_q[4*i +: 4];
      hex_d[7*i +: 7] = seg7(d);
      lead = lead & (d == 4'd0);
`ifdef LEADING_ZERO_BLANK_EN
      if (i > 0 && lead) hex_d[7*i +: 7] = 7'h7F;
`endif
    end
    led_d    = '0;
    led_d[0] = (state_q == S_RUN);
    led_d[1] = dir_q;
    led_d[2] = (state_q == S_PAUSE);
    led_d[3] = tick;
    if (state_q == S_DONE) led_d = '1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      vld_q   <= '0;
      acc_q   <= '1;
      arm_q   <= '0;
      dbc_q   <= '0;
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      pre_q   <= '0;
      hex_q   <= {NUM_DIGITS{7'h40}};
      led_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      vld_q   <= vld_d;
      acc_q   <= acc_d;
      arm_q   <= arm_d;
      dbc_q   <= dbc_d;
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      hex_q   <= hex_d;
      led_q   <= led_d;
    end
  end

  assign HEX     = hex_q;
  assign LED_RED = led_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  KEY;
  logic [27:0] HEX;
  logic [9:0]  LED_RED;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .NUM_DIGITS(4), .TICK_DIV(4), .DEBOUNCE_CYCLES(4), .PRESET(16'h0003), .LED_W(10)
  ) dut (
    .clk(clk), .rst(rst), .KEY(KEY), .HEX(HEX), .LED_RED(LED_RED)
  );

  typedef struct {
    string       tag;
    logic [27:0] hex;
    logic [9:0]  led;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail = 0;

  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] t [10];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return t[d];
  endfunction

  function automatic logic [27:0] hex_of(input logic [15:0] c);
    logic [27:0] h;
    for (int i = 0; i < 4; i++) begin
      h[7*i +: 7] = seg(c[4*i +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
      if (i > 0 && (c >> (4*i)) == 16'h0) h[7*i +: 7] = 7'h7F;
`endif
    end
    return h;
  endfunction

  task automatic expect_out(input string tag, input logic [15:0] c, input logic [9:0] led);
    exp_t e;
    e.tag = tag;
    e.hex = hex_of(c);
    e.led = led;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: got no expectation want one queued");
      return;
    end
    e = sb.pop_front();
    assert (HEX === e.hex) else begin
      n_fail++;
      $error("FAIL %s hex: got %h want %h", e.tag, HEX, e.hex);
    end
    n_tests++;
    assert (LED_RED === e.led) else begin
      n_fail++;
      $error("FAIL %s led: got %h want %h", e.tag, LED_RED, e.led);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_led(input int b, input string tag);
    int i;
    i = 0;
    while (LED_RED[b] !== 1'b1 && i < 40) begin
      @(negedge clk);
      i++;
    end
    n_tests++;
    assert (LED_RED[b] === 1'b1) else begin
      n_fail++;
      $error("FAIL %s timeout: LED_RED[%0d] got %b want 1", tag, b, LED_RED[b]);
    end
  endtask

  task automatic press(input int k);
    KEY[k] = 1'b0;
    tick_n(12);
    KEY[k] = 1'b1;
    tick_n(12);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick_n(1);
    rst = 1'b0;
    tick_n(10);
  endtask

  initial begin
    KEY = 3'b111;
    rst = 1'b1;
    tick_n(3);
    expect_out("reset", 16'h0000, 10'h000);
    check_out();
    rst = 1'b0;

    // 1: idle with keys released
    expect_out("idle_100", 16'h0000, 10'h000);
    tick_n(100);
    check_out();

    // 2: glitch rejected, held press starts the run
    KEY[0] = 1'b0; tick_n(2); KEY[0] = 1'b1;
    expect_out("glitch", 16'h0000, 10'h000);
    tick_n(12);
    check_out();
    KEY[0] = 1'b0;
    wait_led(0, "start");
    expect_out("run_start", 16'h0000, 10'h001);
    check_out();
    expect_out("run_40", 16'h0010, 10'h001);
    tick_n(40);
    check_out();

    // 3: run up to 9999, then wrap
    expect_out("at_9999", 16'h9999, 10'h001);
    tick_n(39956);
    check_out();
    expect_out("wrap", 16'h0000, 10'h001);
    tick_n(4);
    check_out();
    KEY[0] = 1'b1;
    tick_n(12);

    // 4: countdown to DONE, clear back to preset
    do_reset();
    press(2);
    expect_out("down_load", 16'h0003, 10'h002);
    check_out();
    KEY[0] = 1'b0;
    wait_led(0, "down_start");
    expect_out("down_3", 16'h0003, 10'h003);
    check_out();
    expect_out("down_2", 16'h0002, 10'h003);
    tick_n(4); check_out();
    expect_out("down_1", 16'h0001, 10'h003);
    tick_n(4); check_out();
    expect_out("done", 16'h0000, 10'h3FF);
    tick_n(4); check_out();
    KEY[0] = 1'b1;
    expect_out("done_hold", 16'h0000, 10'h3FF);
    tick_n(12); check_out();
    press(1);
    expect_out("done_clear", 16'h0003, 10'h002);
    check_out();

    // 5: pause freezes count and keeps prescaler phase; clear wins in PAUSE
    do_reset();
    KEY[0] = 1'b0;
    wait_led(0, "p_start");
    KEY[0] = 1'b1;
    tick_n(10);
    KEY[0] = 1'b0;
    wait_led(2, "pause");
    expect_out("pause_0", 16'h0004, 10'h004);
    check_out();
    expect_out("pause_20", 16'h0004, 10'h004);
    tick_n(20); check_out();
    KEY[0] = 1'b1;
    tick_n(10);
    KEY[0] = 1'b0;
    wait_led(0, "resume");
    expect_out("resume_0", 16'h0004, 10'h001);
    check_out();
    expect_out("resume_2", 16'h0004, 10'h009);
    tick_n(2); check_out();
    expect_out("resume_3", 16'h0005, 10'h001);
    tick_n(1); check_out();
    KEY[0] = 1'b1;
    tick_n(10);
    KEY[0] = 1'b0;
    wait_led(2, "pause2");
    KEY[0] = 1'b1;
    tick_n(10);
    KEY = 3'b100;
    expect_out("clear_wins", 16'h0000, 10'h000);
    tick_n(12); check_out();
    KEY = 3'b111;
    tick_n(12);

    // 6: reset mid-run with key held; held key ignored until re-pressed
    KEY[0] = 1'b0;
    wait_led(0, "r_start");
    tick_n(10);
    rst = 1'b1;
    expect_out("mid_rst", 16'h0000, 10'h000);
    tick_n(1); check_out();
    rst = 1'b0;
    expect_out("held_ignored", 16'h0000, 10'h000);
    tick_n(30); check_out();
    KEY[0] = 1'b1;
    tick_n(12);
    KEY[0] = 1'b0;
    wait_led(0, "repress");
    expect_out("repress", 16'h0000, 10'h001);
    check_out();
    KEY[0] = 1'b1;
    tick_n(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
